aes_text_out_stage: RTL and testbench
=====================================

AES_TEXT_OUT_STAGE -- requirements
Module: aes_text_out_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of buffered output blocks (legal values 2..8, power of two).
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous assertion and active-low.
REQ-004 SHALL have port clear, input, 1, a synchronous flush of the buffer and the overflow flag.
REQ-005 SHALL have port done, input, 1, a one-cycle pulse from the cipher core marking the final round.
REQ-006 SHALL have port round_state, input, 128, the final-round state after SubBytes/ShiftRows; byte 15 is [127:120].
REQ-007 SHALL have port round_key, input, 128, the last round key.
REQ-008 SHALL have port text_out, output, 128, the ciphertext block at the buffer head.
REQ-009 SHALL have port out_valid, output, 1, asserted when text_out holds a block.
REQ-010 SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-011 SHALL have port count, output, $clog2(DEPTH+1), the number of blocks held.
REQ-012 SHALL have port overflow, output, 1, a sticky flag for a dropped block.

Function
REQ-013 SHALL compute each block as round_state XOR round_key, sampled only in a cycle where done=1.
REQ-014 SHALL write the block into the buffer tail on that edge; done in cycle N gives out_valid=1 in cycle N+1 when the buffer was empty (latency 1).
REQ-015 SHALL pop the head on any edge where out_valid and out_ready are both 1; text_out SHALL be stable while out_valid=1 and out_ready=0.
REQ-016 SHALL, when done and a pop occur in the same cycle, do both: count is unchanged, including when the buffer is full.
REQ-017 SHALL, when done=1 with the buffer full and no pop that cycle, discard the new block, leave contents unchanged and set overflow=1.
REQ-018 SHALL hold overflow at 1 until clear or reset.
REQ-019 SHALL wrap the read and write pointers modulo DEPTH; full means count==DEPTH, empty means count==0.
REQ-020 SHALL give clear priority over done and pop in the same cycle: count=0, out_valid=0, overflow=0 next cycle, and the concurrent done is dropped without setting overflow.
REQ-021 SHALL drive text_out to all zeros whenever out_valid=0.
REQ-022 SHALL ignore out_ready when out_valid=0.

Reset
REQ-023 SHALL, while rst=0, force count=0, out_valid=0, text_out=0, overflow=0 and both pointers to 0, regardless of clk.
REQ-024 SHALL discard any in-flight block when reset occurs mid-operation; no block is emitted after reset is released until a new done.
REQ-025 SHALL leave the storage array contents unreset; they are not observable per REQ-021.

Configuration
REQ-026 SHALL, with AES_TEXT_OUT_PARITY_EN defined, add output out_parity[15:0] giving even parity per byte of text_out, computed at capture, stored alongside the block, and 0 when out_valid=0.
REQ-027 SHALL, without AES_TEXT_OUT_PARITY_EN, have no out_parity port and no parity storage; all other behaviour is identical.

Structure
REQ-028 SHALL take AES_BLK_W=128, AES_NBYTES=16, typedef aes_block_t and typedef aes_parity_t from the shared package aes_out_pkg.
REQ-029 SHALL implement storage and pointers in one sub-module, aes_out_fifo, parameterised by DEPTH and entry width; the XOR and parity logic stays in the top level.

Verification
REQ-030 SHALL cover single block: round_state=0x00112233445566778899aabbccddeeff, round_key=0x0f0e0d0c0b0a09080706050403020100, done pulse, out_ready=1 -> next cycle out_valid=1, text_out=0x0f1f2f3f4f5f6f7f8f9fafbfcfdfefff, count=1; the following cycle out_valid=0.
REQ-031 SHALL cover backpressure: with out_ready=0, three done pulses (DEPTH=2) -> count=2, overflow=1, and the first two blocks drain in order once out_ready=1.
REQ-032 SHALL cover full with simultaneous push and pop: count=2, done and out_ready=1 in the same cycle -> count stays 2, overflow=0, and the new block is last out.
REQ-033 SHALL cover clear with done: clear=1 and done=1 in the same cycle with count=1 and overflow=1 -> count=0, out_valid=0, overflow=0, text_out=0.
REQ-034 SHALL cover reset mid-stream: rst asserted low with count=2, between clock edges -> outputs are zero immediately; after release, out_valid stays 0 until the next done.
REQ-035 SHALL cover parity (macro defined): block 0x01 repeated 16 times -> out_parity=0xFFFF; all-zero block -> out_parity=0x0000.

Source files
------------

// File: rtl/aes_out_pkg.sv
// ----------------------------------------------------------------------------
// aes_out_pkg
//   Shared constants and types for the AES ciphertext output path.
//
//   AES_BLK_W    : width of one AES block in bits (128)
//   AES_NBYTES   : number of bytes per block (16)
//   aes_block_t  : one 128-bit block, byte 15 in [127:120]
//   aes_parity_t : one parity bit per byte of a block
// ----------------------------------------------------------------------------
package aes_out_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_NBYTES = 16;

    typedef logic [AES_BLK_W-1:0]  aes_block_t;
    typedef logic [AES_NBYTES-1:0] aes_parity_t;

endpackage

// File: rtl/aes_out_fifo.sv
// ----------------------------------------------------------------------------
// aes_out_fifo
//   Small circular buffer holding finished output entries. Pointers wrap
//   modulo DEPTH (DEPTH is a power of two, so plain binary wrap works).
//   A push into a full buffer is accepted only when a pop happens on the same
//   edge; otherwise it is dropped and reported on `drop` for one cycle.
//   The storage array itself is never reset; the head is only meaningful
//   while head_valid is high.
//
//   Parameters
//     DEPTH      : number of entries (2..8, power of two)
//     WIDTH      : entry width in bits
//   Ports
//     clk        : clock, rising edge
//     rst        : asynchronous active-low reset of pointers and count
//     clear      : synchronous flush, overrides push and pop
//     push       : write push_data at the tail this edge
//     push_data  : entry to store
//     ready      : downstream accept; pops the head when head_valid is high
//     head_data  : entry at the head (undefined when head_valid is low)
//     head_valid : buffer holds at least one entry
//     count      : number of entries held
//     drop       : push this cycle is being discarded (buffer full, no pop)
// ----------------------------------------------------------------------------
module aes_out_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         ready,
    output logic [WIDTH-1:0]             head_data,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;

    logic empty;
    logic full;
    logic pop;
    logic wr_en;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign pop   = !empty && ready;

    // A full buffer still takes a new entry when the head leaves on the
    // same edge; the freed slot is exactly the one the write pointer hits.
    assign wr_en = push && !clear && (!full || pop);
    assign drop  = push && !clear && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data  = mem[rd_ptr];
    assign head_valid = !empty;
    assign count      = cnt;

endmodule

// File: rtl/aes_text_out_stage.sv
// ----------------------------------------------------------------------------
// aes_text_out_stage
//   Final AddRoundKey of an AES core plus a small output buffer with
//   valid/ready handshake. On every cycle with done=1 the block
//   round_state ^ round_key is pushed into the buffer; the head is presented
//   on text_out with out_valid and leaves when out_ready is high.
//   A block arriving while the buffer is full (and nothing leaves that cycle)
//   is discarded and sets the sticky overflow flag.
//
//   Optional feature (compile-time macro AES_TEXT_OUT_PARITY_EN):
//     adds output out_parity[15:0], even parity per byte of text_out,
//     computed when the block is captured and stored with it.
//
//   Parameters
//     DEPTH       : buffered blocks (2..8, power of two)
//   Ports
//     clk         : clock, rising edge
//     rst         : asynchronous active-low reset
//     clear       : synchronous flush of buffer and overflow flag
//     done        : one-cycle pulse marking the final round
//     round_state : final-round state after SubBytes/ShiftRows
//     round_key   : last round key
//     text_out    : ciphertext at buffer head, zero when out_valid=0
//     out_valid   : text_out holds a block
//     out_ready   : downstream accept
//     count       : blocks held
//     overflow    : sticky, a block was dropped
//     out_parity  : (macro only) per-byte even parity of text_out
// ----------------------------------------------------------------------------
module aes_text_out_stage
    import aes_out_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         done,
    input  aes_block_t                   round_state,
    input  aes_block_t                   round_key,
    output aes_block_t                   text_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
`ifdef AES_TEXT_OUT_PARITY_EN
    output aes_parity_t                  out_parity,
`endif
    output logic                         overflow
);

`ifdef AES_TEXT_OUT_PARITY_EN
    localparam int ENTRY_W = AES_BLK_W + AES_NBYTES;

    // Parity bit per byte such that byte plus parity bit has an even number
    // of ones, i.e. the XOR of the byte's bits.
    function automatic aes_parity_t byte_parity(input aes_block_t blk);
        aes_parity_t p;
        p = '0;
        for (int i = 0; i < AES_NBYTES; i++) begin
            p[i] = ^blk[8*i +: 8];
        end
        return p;
    endfunction
`else
    localparam int ENTRY_W = AES_BLK_W;
`endif

    // ---- stage p0: final AddRoundKey and entry assembly ----
    aes_block_t         blk_p0;
    logic               vld_p0;
    logic [ENTRY_W-1:0] entry_p0;

    assign blk_p0 = round_state ^ round_key;
    assign vld_p0 = done;

`ifdef AES_TEXT_OUT_PARITY_EN
    assign entry_p0 = {byte_parity(blk_p0), blk_p0};
`else
    assign entry_p0 = blk_p0;
`endif

    // ---- stage p1: buffered block at the head ----
    logic [ENTRY_W-1:0] head_p1;
    logic               vld_p1;
    logic               drop_p1;

    aes_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .push       (vld_p0),
        .push_data  (entry_p0),
        .ready      (out_ready),
        .head_data  (head_p1),
        .head_valid (vld_p1),
        .count      (count),
        .drop       (drop_p1)
    );

    // The storage array is not reset, so the head is masked whenever the
    // buffer is empty; this also zeroes the outputs immediately on reset.
    assign out_valid = vld_p1;
    assign text_out  = vld_p1 ? head_p1[AES_BLK_W-1:0] : '0;

`ifdef AES_TEXT_OUT_PARITY_EN
    assign out_parity = vld_p1 ? head_p1[ENTRY_W-1 -: AES_NBYTES] : '0;
`endif

    // clear wins over a concurrent drop: drop_p1 is already gated by clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (drop_p1) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_text_out_stage.sv
module tb_aes_text_out_stage;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk;
    logic          rst;
    logic          clear;
    logic          done;
    logic [127:0]  round_state;
    logic [127:0]  round_key;
    logic [127:0]  text_out;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          overflow;
`ifdef AES_TEXT_OUT_PARITY_EN
    logic [15:0]   out_parity;
`endif

    int errors = 0;
    int checks = 0;

    aes_text_out_stage #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .done        (done),
        .round_state (round_state),
        .round_key   (round_key),
        .text_out    (text_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
`ifdef AES_TEXT_OUT_PARITY_EN
        .out_parity  (out_parity),
`endif
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample #1 after the edge.
    task automatic drive(input bit c, input bit d, input bit r,
                         input logic [127:0] rs, input logic [127:0] rk);
        clear       = c;
        done        = d;
        out_ready   = r;
        round_state = rs;
        round_key   = rk;
        @(posedge clk);
        #1;
        clear = 1'b0;
        done  = 1'b0;
    endtask

    // ---------------- reference model: a bounded queue ----------------
    logic [127:0] mq[$];
    bit           m_ovf;

    task automatic model_step(input bit c, input bit d, input bit r, input logic [127:0] blk);
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (r && mq.size() > 0) void'(mq.pop_front());
            if (d) begin
                if (mq.size() < DEPTH) mq.push_back(blk);
                else m_ovf = 1'b1;
            end
        end
    endtask

    function automatic logic [15:0] ref_parity(input logic [127:0] b);
        logic [15:0] p;
        for (int i = 0; i < 16; i++) begin
            int ones;
            ones = 0;
            for (int j = 0; j < 8; j++) ones += int'(b[8*i+j]);
            p[i] = (ones % 2) == 1;
        end
        return p;
    endfunction

    task automatic check_model(input string tag);
        logic [127:0] exp_text;
        exp_text = (mq.size() > 0) ? mq[0] : 128'h0;
        chk({tag, ".valid"}, 128'(out_valid), 128'(mq.size() > 0));
        chk({tag, ".text"}, text_out, exp_text);
        chk({tag, ".count"}, 128'(count), 128'(mq.size()));
        chk({tag, ".ovf"}, 128'(overflow), 128'(m_ovf));
`ifdef AES_TEXT_OUT_PARITY_EN
        chk({tag, ".par"}, 128'(out_parity), 128'((mq.size() > 0) ? ref_parity(exp_text) : 16'h0));
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit           c;
        bit           d;
        bit           r;
        logic [127:0] rs;
        logic [127:0] rk;
        bit           ev;
        logic [127:0] et;
        int           ec;
        bit           eo;
    } vec_t;

    function automatic vec_t v(input bit c, input bit d, input bit r,
                               input logic [127:0] rs, input logic [127:0] rk,
                               input bit ev, input logic [127:0] et, input int ec, input bit eo);
        vec_t x;
        x.c = c; x.d = d; x.r = r; x.rs = rs; x.rk = rk;
        x.ev = ev; x.et = et; x.ec = ec; x.eo = eo;
        return x;
    endfunction

    localparam logic [127:0] RS_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RK_A = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] X_A  = 128'h0f1f2f3f4f5f6f7f8f9fafbfcfdfefff;
    localparam logic [127:0] B    = 128'h0000_0000_0000_0000_0000_0000_0000_00b1;
    localparam logic [127:0] C    = 128'hc200_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [127:0] D    = 128'hdddd_0000_1111_0000_2222_0000_3333_0000;
    localparam logic [127:0] Z    = 128'h0;

    vec_t tbl[19];

    initial begin
        rst = 1'b1; clear = 1'b0; done = 1'b0; out_ready = 1'b0;
        round_state = '0; round_key = '0;

        // ---- reset state ----
        #1 rst = 1'b0;
        #1;
        chk("rst.valid", 128'(out_valid), 128'(0));
        chk("rst.text", text_out, Z);
        chk("rst.count", 128'(count), 128'(0));
        chk("rst.ovf", 128'(overflow), 128'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // ---- table: single block, backpressure, full push+pop, clear+done ----
        tbl[0]  = v(0, 1, 1, RS_A, RK_A, 1, X_A, 1, 0);
        tbl[1]  = v(0, 0, 1, Z, Z, 0, Z, 0, 0);
        tbl[2]  = v(0, 1, 0, B, Z, 1, B, 1, 0);
        tbl[3]  = v(0, 1, 0, C, Z, 1, B, 2, 0);
        tbl[4]  = v(0, 1, 0, D, Z, 1, B, 2, 1);
        tbl[5]  = v(0, 0, 1, Z, Z, 1, C, 1, 1);
        tbl[6]  = v(0, 0, 1, Z, Z, 0, Z, 0, 1);
        tbl[7]  = v(1, 0, 0, Z, Z, 0, Z, 0, 0);
        tbl[8]  = v(0, 1, 0, B, Z, 1, B, 1, 0);
        tbl[9]  = v(0, 1, 0, C, Z, 1, B, 2, 0);
        tbl[10] = v(0, 1, 1, D, Z, 1, C, 2, 0);
        tbl[11] = v(0, 0, 1, Z, Z, 1, D, 1, 0);
        tbl[12] = v(0, 0, 1, Z, Z, 0, Z, 0, 0);
        tbl[13] = v(0, 1, 0, B, Z, 1, B, 1, 0);
        tbl[14] = v(0, 1, 0, C, Z, 1, B, 2, 0);
        tbl[15] = v(0, 1, 0, D, Z, 1, B, 2, 1);
        tbl[16] = v(0, 0, 1, Z, Z, 1, C, 1, 1);
        tbl[17] = v(1, 1, 0, D, Z, 0, Z, 0, 0);
        tbl[18] = v(0, 0, 1, Z, Z, 0, Z, 0, 0);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].c, tbl[i].d, tbl[i].r, tbl[i].rs, tbl[i].rk);
            chk($sformatf("vec%0d.valid", i), 128'(out_valid), 128'(tbl[i].ev));
            chk($sformatf("vec%0d.text", i), text_out, tbl[i].et);
            chk($sformatf("vec%0d.count", i), 128'(count), 128'(tbl[i].ec));
            chk($sformatf("vec%0d.ovf", i), 128'(overflow), 128'(tbl[i].eo));
        end

        // ---- reset mid-stream, asserted between edges ----
        drive(0, 1, 0, B, Z);
        drive(0, 1, 0, C, Z);
        chk("mid.count_before", 128'(count), 128'(2));
        #3 rst = 1'b0;
        #1;
        chk("mid.valid", 128'(out_valid), 128'(0));
        chk("mid.text", text_out, Z);
        chk("mid.count", 128'(count), 128'(0));
        chk("mid.ovf", 128'(overflow), 128'(0));
        @(posedge clk); #1;
        chk("mid.hold_count", 128'(count), 128'(0));
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, Z, Z);
            chk($sformatf("post%0d.valid", i), 128'(out_valid), 128'(0));
        end
        drive(0, 1, 0, D, Z);
        chk("post.new_valid", 128'(out_valid), 128'(1));
        chk("post.new_text", text_out, D);
        drive(0, 0, 1, Z, Z);
        chk("post.drained", 128'(count), 128'(0));

`ifdef AES_TEXT_OUT_PARITY_EN
        // ---- parity ----
        drive(0, 1, 0, {16{8'h01}}, Z);
        chk("par.ones", 128'(out_parity), 128'(16'hffff));
        drive(0, 1, 1, Z, Z);
        chk("par.zero_valid", 128'(out_valid), 128'(1));
        chk("par.zero", 128'(out_parity), 128'(16'h0000));
        drive(0, 0, 1, Z, Z);
        chk("par.empty", 128'(out_parity), 128'(16'h0000));
`endif

        // ---- randomized run against the queue model ----
        mq.delete();
        m_ovf = 1'b0;
        for (int n = 0; n < 400; n++) begin
            bit c, d, r;
            logic [127:0] rs, rk;
            c  = ($urandom_range(0, 31) == 0);
            d  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 45);
            rs = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            model_step(c, d, r, rs ^ rk);
            drive(c, d, r, rs, rk);
            check_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
